// File: rtl/pid_plant_emulator_if.sv
// Signal bundle between a PID loop driver and the plant emulator.
//   enable          : plant runs when high, holds everything when low
//   control_signal  : 8-bit unsigned actuator command
//   disturbance     : 8-bit signed load disturbance added at the output
//   feedback        : 8-bit unsigned measured plant output
//   sample_tick     : one-clock strobe marking a new plant state on feedback
//   settled         : plant state within 1 LSB of the delayed command
// master drives the command side, slave is the plant.
interface pid_plant_emulator_if;
   logic       enable;
   logic [7:0] control_signal;
   logic [7:0] disturbance;
   logic [7:0] feedback;
   logic       sample_tick;
   logic       settled;

   modport master (
      output enable, control_signal, disturbance,
      input  feedback, sample_tick, settled
   );

   modport slave (
      input  enable, control_signal, disturbance,
      output feedback, sample_tick, settled
   );
endinterface

// File: rtl/pid_plant_emulator.sv
// First-order lag plant with transport delay and additive output disturbance.
// The plant state advances once per DIV enabled clocks.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of pid_plant_emulator_if (command in, feedback out)
// Parameters:
//   DIV    : clocks per plant sample (1..65535)
//   SHIFT  : time constant of 2^SHIFT samples (0..7)
//   DELAY  : transport delay in samples (0..7)
//   Y_INIT : integer part of the plant output after reset
module pid_plant_emulator #(
   parameter int unsigned DIV    = 16,
   parameter int unsigned SHIFT  = 2,
   parameter int unsigned DELAY  = 2,
   parameter logic [7:0]  Y_INIT = 8'h00
) (
   input logic                  clk,
   input logic                  rst,
   pid_plant_emulator_if.slave  bus
);

   localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

   logic [15:0]        cnt;
   logic [15:0]        y;        // Q8.8 plant state
   logic               tick;
   logic               tick_q;
   logic [7:0]         u_d;      // command the next tick will use
   logic signed [16:0] diff;
   logic signed [9:0]  s;
   logic               settled_d;
   logic [7:0]         feedback_d;

   assign tick = bus.enable && (cnt == DIV_M1);

   // Transport delay line; u_d is the oldest tap before this tick's shift.
   generate
      if (DELAY == 0) begin : g_nodelay
         assign u_d = bus.control_signal;
      end else begin : g_delay
         logic [7:0] tap [DELAY];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DELAY; i++) tap[i] <= '0;
            end else if (tick) begin
               tap[0] <= bus.control_signal;
               for (int i = 1; i < DELAY; i++) tap[i] <= tap[i-1];
            end
         end

         assign u_d = tap[DELAY-1];
      end
   endgenerate

   // Error between target and state; the shifted step always lands between
   // y and u_d*256, so the 16-bit sum cannot wrap.
   assign diff = $signed({1'b0, u_d, 8'h00}) - $signed({1'b0, y});

   assign settled_d = (diff >= -17'sd256) && (diff <= 17'sd256);

   assign s = $signed({2'b00, y[15:8]})
            + $signed({{2{bus.disturbance[7]}}, bus.disturbance});

   always_comb begin
      feedback_d = s[7:0];
      if (s < 10'sd0) begin
         feedback_d = 8'h00;
      end else if (s > 10'sd255) begin
         feedback_d = 8'hFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else if (bus.enable) begin
         cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y <= {Y_INIT, 8'h00};
      end else if (tick) begin
         y <= y + 16'(diff >>> SHIFT);
      end
   end

   // tick_q marks the cycle y is new; feedback shows it one edge later, so the
   // strobe is delayed once more to line up with that feedback cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q          <= 1'b0;
         bus.sample_tick <= 1'b0;
         bus.feedback    <= Y_INIT;
         bus.settled     <= 1'b0;
      end else begin
         tick_q          <= tick;
         bus.sample_tick <= tick_q;
         bus.feedback    <= feedback_d;
         bus.settled     <= settled_d;
      end
   end

endmodule

// File: tb/tb_pid_plant_emulator.sv
// Scoreboard bench for pid_plant_emulator: directed scenarios followed by
// randomized stimulus, all checked against a behavioural plant model.
module tb_pid_plant_emulator;
   localparam int unsigned DIV    = 4;
   localparam int unsigned SHIFT  = 2;
   localparam int unsigned DELAY  = 2;
   localparam logic [7:0]  Y_INIT = 8'h00;

   logic clk = 1'b0;
   logic rst;

   pid_plant_emulator_if bus_if ();

   pid_plant_emulator #(
      .DIV    (DIV),
      .SHIFT  (SHIFT),
      .DELAY  (DELAY),
      .Y_INIT (Y_INIT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int fb;
      bit st;
      bit set;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model state: plant value in 1/256 units, enabled clocks since the last
   // sample, commands captured at past samples (newest first).
   int m_y;
   int m_cnt;
   int m_hist[$];
   bit m_prev_tick;

   function automatic int clamp8(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   // Expected outputs visible after the coming clock edge, given the inputs
   // applied for that edge.
   task automatic model_step(input bit r, input bit en, input int u, input int d);
      exp_t e;
      int   ud, target, dlt, den, step;
      if (r) begin
         e.fb = int'(Y_INIT);
         e.st = 1'b0;
         e.set = 1'b0;
         m_y = int'(Y_INIT) * 256;
         m_cnt = 0;
         m_hist.delete();
         for (int i = 0; i < int'(DELAY); i++) m_hist.push_back(0);
         m_prev_tick = 1'b0;
      end else begin
         ud = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : u;
         e.fb = clamp8(m_y / 256 + ((d > 127) ? d - 256 : d));
         e.st = m_prev_tick;
         target = ud * 256;
         e.set = (target - m_y <= 256) && (m_y - target <= 256);
         m_prev_tick = en && (m_cnt == int'(DIV) - 1);
         if (m_prev_tick) begin
            dlt  = target - m_y;
            den  = 1 << SHIFT;
            step = dlt / den;
            if (dlt < 0 && (dlt % den) != 0) step = step - 1;
            m_y  = m_y + step;
            m_cnt = 0;
            if (m_hist.size() > 0) begin
               m_hist.push_front(u);
               void'(m_hist.pop_back());
            end
         end else if (en) begin
            m_cnt = m_cnt + 1;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit r, input bit en, input int u, input int d);
      @(negedge clk);
      rst                   = r;
      bus_if.enable         = en;
      bus_if.control_signal = 8'(u);
      bus_if.disturbance    = 8'(d);
      model_step(r, en, u, d);
   endtask

   // Monitor: one expected entry per clock edge once stimulus has started.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus_if.feedback !== 8'(e.fb) || bus_if.sample_tick !== e.st
                || bus_if.settled !== e.set) begin
               errors++;
               $display("FAIL scoreboard t=%0t: got fb=%0d tick=%b settled=%b, want fb=%0d tick=%b settled=%b",
                        $time, bus_if.feedback, bus_if.sample_tick, bus_if.settled,
                        e.fb, e.st, e.set);
            end
         end
      end
   end

   // Feedback on successive sample_ticks after a 0->128 step applied just
   // after a tick: DELAY ticks of no response, then the 2^-SHIFT lag curve.
   task automatic watch_step_ticks();
      int want[7] = '{0, 0, 0, 32, 56, 74, 87};
      int seen = 0;
      for (int c = 0; c < 120 && seen < 7; c++) begin
         @(posedge clk);
         #2;
         if (bus_if.sample_tick === 1'b1) begin
            checks++;
            if (bus_if.feedback !== 8'(want[seen])) begin
               errors++;
               $display("FAIL step_tick%0d: got fb=%0d, want %0d", seen, bus_if.feedback,
                        want[seen]);
            end
            seen++;
         end
      end
      if (seen < 7) begin
         checks++;
         errors++;
         $display("FAIL step_timeout: got %0d sample_ticks, want 7", seen);
      end
   endtask

   task automatic run_step_test();
      for (int i = 0; i < int'(DIV); i++) drive(0, 1, 0, 0);
      fork
         for (int i = 0; i < 30; i++) drive(0, 1, 128, 0);
         watch_step_ticks();
      join
   endtask

   initial begin
      int u;
      int d;
      rst = 1'b1;
      bus_if.enable = 1'b1;
      bus_if.control_signal = 8'd200;
      bus_if.disturbance = 8'd0;

      // Reset held with enable and a large command.
      drive(1, 1, 200, 0);
      drive(1, 1, 200, 0);

      // Delayed first-order step response.
      run_step_test();

      // Settle near 100, then saturate low.
      for (int i = 0; i < 120; i++) drive(0, 1, 100, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 100, 8'h88);
      for (int i = 0; i < 3; i++) drive(0, 1, 100, 0);

      // Settle near 200, then saturate high.
      for (int i = 0; i < 160; i++) drive(0, 1, 200, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, 200, 8'h7F);
      for (int i = 0; i < 3; i++) drive(0, 1, 200, 0);

      // Hold with enable low, entered with the count on its last value.
      drive(0, 1, 50, 0);
      for (int i = 0; i < 8 && m_cnt != int'(DIV) - 1; i++) drive(0, 1, 50, 0);
      for (int i = 0; i < 10; i++) drive(0, 0, 50, 0);
      for (int i = 0; i < 12; i++) drive(0, 1, 50, 0);

      // Hold entered mid-count.
      for (int i = 0; i < 10; i++) drive(0, 0, 50, 0);
      for (int i = 0; i < 12; i++) drive(0, 1, 50, 0);

      // Abort mid-convergence; the delay line must start empty again.
      drive(0, 1, 220, 0);
      drive(0, 1, 220, 0);
      drive(1, 1, 220, 0);
      run_step_test();

      // Randomized traffic.
      u = 0;
      d = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 19) == 0) u = int'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) begin
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 15));
         end
         drive($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 85, u, d);
      end

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pid_plant_emulator.md
Name: pid_plant_emulator

Overview:
- Closed-loop counterpart of the PID controller: consumes the 8-bit control_signal and produces the 8-bit feedback the controller reads.
- Emulates a first-order lag plant with a transport delay and an additive disturbance input.
- Used for on-chip loop tests and for verifying the PID controller.
- Plant state updates once per sample period, set by a clock prescaler.

Parameters:
- DIV, 16: clocks per plant sample; legal range 1..65535.
- SHIFT, 2: time constant, equal to 2^SHIFT samples; legal range 0..7.
- DELAY, 2: transport delay in samples; legal range 0..7.
- Y_INIT, 8'h00: plant output after reset (integer part).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = prescaler runs and the plant evolves; 0 = everything holds.
- control_signal  in  8  unsigned actuator command u. Sampled only on tick cycles.
- disturbance  in  8  signed two's-complement load disturbance added at the output.
- feedback  out  8  unsigned measured plant output, registered.
- sample_tick  out  1  one-clock strobe, high in the first cycle feedback shows a new plant state.
- settled  out  1  registered; plant state is within 1 LSB of the delayed command.

Behaviour:
- Reset is synchronous: on an rst=1 edge, regardless of enable or mid-count state:
  - cnt<=0; every delay tap<=0; y<={Y_INIT,8'h00}.
  - feedback<=Y_INIT; sample_tick<=0; settled<=0.
- Prescaler: 16-bit cnt.
  - tick = enable && cnt==DIV-1.
  - On tick, cnt<=0. Otherwise, if enable, cnt<=cnt+1.
  - enable=0 holds cnt (no clear) and holds y and the taps.
- State y: 16-bit unsigned, Q8.8 format.
- Delayed command u_d:
  - DELAY=0: u_d = control_signal in the tick cycle.
  - DELAY>0: u_d = tap[DELAY-1], the value before this tick's shift.
  - On tick: tap[0]<=control_signal; tap[i]<=tap[i-1].
  - A step on control_signal therefore first affects y on tick number DELAY+1 after the step.
- Update on tick:
  - diff = {u_d,8'h00} - y, 17-bit signed.
  - y <= y + (diff >>> SHIFT), arithmetic shift (floors toward -inf).
  - The result always lies between y and u_d*256 inclusive, so no overflow is possible.
  - SHIFT=0 gives y=u_d*256 exactly.
- Output stage, registered every clock (not only on ticks):
  - s = y[15:8] + disturbance (signed, 10-bit).
  - feedback <= s<0 ? 0 : s>255 ? 255 : s[7:0].
  - Disturbance-to-feedback latency is 1 clock.
- Timing:
  - y changes at the tick edge; feedback reflects it one edge later.
  - sample_tick is tick delayed by one register, so it aligns with the first feedback cycle showing the new y.
- Settled: registered every clock as settled <= |{u_d_cur,8'h00} - y| <= 256.
  - u_d_cur is the u_d value that the next tick would use (tap[DELAY-1], or control_signal when DELAY=0).
- Boundary behaviour:
  - DIV=1: tick on every enabled clock.
  - enable dropping in the same cycle cnt reaches DIV-1: no tick; cnt holds at DIV-1, and the tick fires on the first enabled clock afterwards.
  - rst and tick in the same cycle: rst wins.
  - Changes to control_signal between ticks are ignored.

Test Plan:
1. Reset. Y_INIT=8'h00; hold rst=1 for 2 clocks with enable=1 and u=200 → feedback=0, sample_tick=0, settled=0. cnt stays 0 while rst is held.
2. Fast plant. DIV=4, SHIFT=0, DELAY=0; release reset, enable=1, u=200 → first sample_tick 5 clocks after the first enabled edge, feedback=200 in that cycle, settled=1 from the same cycle.
3. First-order step. DIV=4, SHIFT=2, DELAY=0; u=128 from y=0.
   - Feedback on successive sample_ticks: 32, 56, 74, 87.
   - Keeps converging; settled=1 once y≥0x7F00.
4. Transport delay. DELAY=2, SHIFT=0; u changes 0→90 just after a tick → feedback stays 0 on the next 2 sample_ticks and reads 90 on the 3rd.
5. Disturbance saturation. Plant settled at 100:
   - disturbance=8'h88 (-120) → feedback=0 one clock later.
   - Settle at 200, disturbance=8'h7F → feedback=255.
   - disturbance=0 → feedback restores within 1 clock.
6. Hold and abort.
   - Drop enable at cnt=2 for 10 clocks: no sample_tick, feedback constant; the next tick arrives DIV-2 enabled clocks later.
   - Assert rst mid-convergence: feedback=Y_INIT on the following cycle, delay taps cleared (a subsequent DELAY=2 step again waits 3 ticks).
